uart_tx_core: RTL and testbench



---
 rtl/uart_tx_core.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_core.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART 8N1 transmitter engine with fractional baud generator
// Optional feature macro: UART_TX_PARITY_EN (even parity bit between data and stop)
module uart_tx_core #(
   parameter int CLK_UNIT_HZ = 1000000,
   parameter int ACC_W       = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic       start_i,
   input  logic [3:0] br_i,
   input  logic [7:0] clk_mhz_i,
   input  logic [7:0] data_i,
   output logic       tx_o,
   output logic       busy_o,
   output logic       done_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   state_t             state_q, state_n;
   logic [ACC_W-1:0]   acc_q, acc_n, sum;
   logic [ACC_W-1:0]   baud_q, clk_hz_q;
   logic [7:0]         shift_q, shift_n;
   logic [2:0]         bit_cnt_q;
   logic               start_q;
   logic               start_evt;
   logic               tick;
   logic               tx_n, busy_n, done_n;
`ifdef UART_TX_PARITY_EN
   logic               parity_q;
`endif

   // Baud rate in bits per second for each selector code; unused codes fall back to 115200
   function automatic logic [ACC_W-1:0] baud_of(input logic [3:0] br);
      case (br)
         4'd0:    baud_of = ACC_W'(1200);
         4'd1:    baud_of = ACC_W'(2400);
         4'd2:    baud_of = ACC_W'(4800);
         4'd3:    baud_of = ACC_W'(9600);
         4'd4:    baud_of = ACC_W'(14400);
         4'd5:    baud_of = ACC_W'(19200);
         4'd6:    baud_of = ACC_W'(28800);
         4'd7:    baud_of = ACC_W'(38400);
         4'd8:    baud_of = ACC_W'(57600);
         4'd10:   baud_of = ACC_W'(230400);
         4'd11:   baud_of = ACC_W'(460800);
         4'd12:   baud_of = ACC_W'(921600);
         default: baud_of = ACC_W'(115200);
      endcase
   endfunction

   // Only a fresh rising edge while idle, enabled and with a usable clock field starts a frame
   assign start_evt = start_i && !start_q && en_i && (clk_mhz_i != 8'd0) && (state_q == IDLE);

   // Fractional baud accumulator: adds baud per cycle, a tick marks each elapsed bit period
   always_comb begin
      sum   = acc_q + baud_q;
      tick  = 1'b0;
      acc_n = sum;
      if (baud_q >= clk_hz_q) begin
         tick  = 1'b1;
         acc_n = '0;
      end else if (sum >= clk_hz_q) begin
         tick  = 1'b1;
         acc_n = sum - clk_hz_q;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_n;
   end

   // Next state, next shift contents and next registered outputs
   always_comb begin
      state_n = state_q;
      shift_n = shift_q;
      done_n  = 1'b0;
      tx_n    = 1'b1;
      case (state_q)
         IDLE: begin
            if (start_evt) begin
               state_n = START;
               shift_n = data_i;
            end
         end
         START: begin
            if (tick) state_n = DATA;
         end
         DATA: begin
            if (tick) begin
               shift_n = {1'b0, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (tick) state_n = STOP;
         end
`endif
         STOP: begin
            if (tick) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      // Dropping enable abandons the frame without a completion pulse
      if (!en_i) begin
         state_n = IDLE;
         done_n  = 1'b0;
      end
      busy_n = (state_n != IDLE);
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_n = parity_q;
`endif
         default: tx_n = 1'b1;
      endcase
   end

   // Datapath: edge detect, frame parameter latch, accumulator, bit counter, outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         start_q   <= 1'b0;
         acc_q     <= '0;
         baud_q    <= '0;
         clk_hz_q  <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_o      <= 1'b1;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         start_q <= start_i;
         shift_q <= shift_n;
         tx_o    <= tx_n;
         busy_o  <= busy_n;
         done_o  <= done_n;
         if (start_evt) begin
            baud_q    <= baud_of(br_i);
            clk_hz_q  <= ACC_W'(clk_mhz_i) * ACC_W'(CLK_UNIT_HZ);
            acc_q     <= '0;
            bit_cnt_q <= '0;
         end else if (state_n == IDLE) begin
            acc_q     <= '0;
            bit_cnt_q <= '0;
         end else begin
            acc_q <= acc_n;
            if (state_q == DATA && tick) bit_cnt_q <= bit_cnt_q + 3'd1;
         end
      end
   end

`ifdef UART_TX_PARITY_EN
   // Even parity of the byte captured at frame start
   always_ff @(posedge clk) begin
      if (rst)            parity_q <= 1'b0;
      else if (start_evt) parity_q <= ^data_i;
   end
`endif

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - randomized self-checking bench for uart_tx_core against a bit-boundary model
module tb_uart_tx_core;

   logic       clk = 1'b0;
   logic       rst;
   logic       en_i;
   logic       start_i;
   logic [3:0] br_i;
   logic [7:0] clk_mhz_i;
   logic [7:0] data_i;
   logic       tx_o;
   logic       busy_o;
   logic       done_o;

   int n_checks = 0;
   int n_pass   = 0;
   int obs_done_cyc;
   int obs_first_high;

   int baud_tab [16] = '{1200, 2400, 4800, 9600, 14400, 19200, 28800, 38400,
                         57600, 115200, 230400, 460800, 921600, 115200, 115200, 115200};

   uart_tx_core dut (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en_i),
      .start_i   (start_i),
      .br_i      (br_i),
      .clk_mhz_i (clk_mhz_i),
      .data_i    (data_i),
      .tx_o      (tx_o),
      .busy_o    (busy_o),
      .done_o    (done_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Cycle (counted from the first START cycle) on which bit period n ends
   function automatic longint bnd(input int n, input longint chz, input longint bd);
      if (bd >= chz) return longint'(n);
      return (longint'(n) * chz + bd - 1) / bd;
   endfunction

   task automatic run_frame(input string tag, input logic [7:0] d, input logic [3:0] br,
                            input logic [7:0] mhz, input int abort_at, input int glitch_at);
      longint chz, bd, end_c, k;
      int     nbits, last, b, mism, jit_bad, nb;
      int     bits [11];
      int     samp [11];
      logic   cap  [11];
      logic   etx, eb, ed, prev_tx;
      logic [7:0] dec;
      chz   = longint'(mhz) * 1000000;
      bd    = longint'(baud_tab[br]);
`ifdef UART_TX_PARITY_EN
      nbits = 11;
`else
      nbits = 10;
`endif
      bits[0] = 0;
      for (int i = 0; i < 8; i++) bits[i+1] = int'(d[i]);
      if (nbits == 11) bits[9] = int'(^d);
      bits[nbits-1] = 1;
      for (int i = 0; i < nbits; i++) samp[i] = int'(((2 * i + 1) * chz) / (2 * bd)) + 1;
      for (int i = 0; i < 11; i++) cap[i] = 1'b0;
      end_c = bnd(nbits, chz, bd);
      if (abort_at != 0) last = abort_at + 1200;
      else               last = int'(end_c) + 2 + (glitch_at != 0 ? 300 : 0);
      mism = 0; jit_bad = 0; obs_done_cyc = 0; obs_first_high = 0; prev_tx = 1'b1;

      @(negedge clk);
      start_i = 1'b0; en_i = 1'b1; data_i = d; br_i = br; clk_mhz_i = mhz;
      @(negedge clk);
      start_i = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         if (abort_at != 0 && c > abort_at) begin
            etx = 1'b1; eb = 1'b0; ed = 1'b0;
         end else if (c <= end_c) begin
            b = 0;
            while (bnd(b + 1, chz, bd) < c) b++;
            etx = bits[b][0]; eb = 1'b1; ed = 1'b0;
         end else if (c == end_c + 1) begin
            etx = 1'b1; eb = 1'b0; ed = 1'b1;
         end else begin
            etx = 1'b1; eb = 1'b0; ed = 1'b0;
         end
         if (tx_o !== etx || busy_o !== eb || done_o !== ed) mism++;
         if (done_o === 1'b1 && obs_done_cyc == 0) obs_done_cyc = c;
         if (tx_o === 1'b1 && obs_first_high == 0) obs_first_high = c;
         for (int i = 0; i < nbits; i++) if (samp[i] == c) cap[i] = tx_o;
         // Every observed edge must sit within one cycle of an ideal bit boundary
         if (abort_at == 0 && c >= 2 && c <= end_c + 1 && tx_o !== prev_tx) begin
            k  = longint'(c - 1);
            nb = int'((k * bd + chz / 2) / chz);
            if (k * bd - longint'(nb) * chz > bd || longint'(nb) * chz - k * bd > bd) jit_bad++;
         end
         prev_tx = tx_o;
         if (glitch_at != 0 && c == glitch_at) start_i = 1'b0;
         if (glitch_at != 0 && c == glitch_at + 1) begin
            start_i = 1'b1;
            data_i  = 8'hFF;
         end
         if (abort_at != 0 && c == abort_at) en_i = 1'b0;
      end

      check({tag, " waveform mismatching cycles"}, mism, 0);
      if (abort_at == 0) begin
         for (int i = 0; i < 8; i++) dec[i] = cap[i+1];
         check({tag, " decoded byte"}, {24'd0, dec}, {24'd0, d});
         check({tag, " start bit"}, {31'd0, cap[0]}, 32'd0);
         check({tag, " stop bit"}, {31'd0, cap[nbits-1]}, 32'd1);
         if (nbits == 11) check({tag, " parity bit"}, {31'd0, cap[9]}, {31'd0, ^d});
         check({tag, " done cycle"}, obs_done_cyc, 32'(end_c + 1));
         check({tag, " boundary jitter"}, jit_bad, 0);
      end else begin
         check({tag, " done after abort"}, obs_done_cyc, 0);
      end
   endtask

   task automatic no_frame(input string tag, input logic en, input logic [7:0] mhz);
      int act;
      act = 0;
      @(negedge clk);
      start_i = 1'b0; en_i = en; clk_mhz_i = mhz; data_i = 8'h5A; br_i = 4'd9;
      @(negedge clk);
      start_i = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (busy_o !== 1'b0 || done_o !== 1'b0 || tx_o !== 1'b1) act++;
      end
      check({tag, " activity cycles"}, act, 0);
   endtask

   initial begin
      int idle_bad;
      logic [7:0] rd;
      logic [3:0] rbr;
      logic [7:0] rmhz;
      rst = 1'b1; en_i = 1'b0; start_i = 1'b0; br_i = 4'hF; clk_mhz_i = 8'd0; data_i = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset tx_o", {31'd0, tx_o}, 32'd1);
      check("reset busy_o", {31'd0, busy_o}, 32'd0);
      check("reset done_o", {31'd0, done_o}, 32'd0);
      rst = 1'b0;
      idle_bad = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) idle_bad++;
      end
      check("idle after reset", idle_bad, 0);

      run_frame("9600@1MHz 0x55", 8'h55, 4'd3, 8'd1, 0, 0);
      check("9600 start bit length", obs_first_high, 106);
`ifdef UART_TX_PARITY_EN
      check("9600 frame end", obs_done_cyc, 1147);
      run_frame("parity 0x07", 8'h07, 4'd3, 8'd1, 0, 0);
      check("parity frame end", obs_done_cyc, 1147);
`else
      check("9600 frame end", obs_done_cyc, 1043);
`endif

      run_frame("115200@50MHz 0xA3", 8'hA3, 4'd9, 8'd50, 0, 0);
      run_frame("mid-frame restart", 8'h3C, 4'd3, 8'd1, 0, 400);
      run_frame("abort at 300", 8'h96, 4'd3, 8'd1, 300, 0);
      run_frame("after abort", 8'h69, 4'd3, 8'd1, 0, 0);
      no_frame("clk_mhz zero", 1'b1, 8'd0);
      no_frame("disabled", 1'b0, 8'd1);

      for (int i = 0; i < 6; i++) begin
         rd   = 8'($urandom);
         rbr  = 4'($urandom_range(15, 8));
         rmhz = 8'($urandom_range(8, 1));
         run_frame($sformatf("random %0d br%0d %0dMHz", i, rbr, rmhz), rd, rbr, rmhz, 0, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
